c32_mem: RTL and testbench

Bus responder for the c32 core's 32-bit memory port. Each core bus cycle is split into four byte accesses on a synchronous 8-bit memory (block RAM, 1-cycle read latency). The block paces the core through its `ce` input: `ce` stays low while a transaction is in flight and is raised for exactly one cycle when the result is ready. It sits between the c32 core and the system byte memory.

---
 rtl/c32_mem_pkg.sv | 28 ++
 rtl/c32_mem.sv | 111 +++++++++++
 tb/tb_c32_mem.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/c32_mem_pkg.sv
// Shared c32 bus declarations: responder state encoding and byte-lane helpers
// used by the memory responder and any other agent on the c32 memory port.
package c32_mem_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_BYTE = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } c32_bus_state_t;

  localparam int unsigned C32_WORD_W = 32;
  localparam int unsigned C32_BYTE_W = 8;

  // Little-endian lane select: lane k is bits [8k+7:8k].
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

  function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[8*idx +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/c32_mem.sv
// c32 memory-port responder: splits each 32-bit core access into four byte
// accesses on a synchronous 8-bit RAM and paces the core through core_ce.
module c32_mem
  import c32_mem_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       core_a,
  input  logic [31:0]       core_o,
  input  logic              core_w,
  output logic [31:0]       core_i,
  output logic              core_ce,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_d,
  output logic              mem_we,
  input  logic [7:0]        mem_q
);

  c32_bus_state_t    state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] req_a_q;
  logic [31:0]       req_o_q;
  logic              req_w_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       core_i_q;
  logic              core_ce_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_d_q;
  logic              mem_we_q;

  logic [1:0]        cnt_d;
  logic [ADDR_W-1:0] lane_addr_d;
  logic              unused_core_a;

  // Address bits above ADDR_W are ignored; the sum wraps modulo 2^ADDR_W.
  assign cnt_d         = cnt_q + 2'd1;
  assign lane_addr_d   = req_a_q + ADDR_W'(cnt_d);
  assign unused_core_a = ^core_a;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_REQ;
      cnt_q     <= 2'd0;
      req_a_q   <= '0;
      req_o_q   <= '0;
      req_w_q   <= 1'b0;
      rbuf_q    <= '0;
      core_i_q  <= '0;
      core_ce_q <= 1'b0;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
      mem_we_q  <= 1'b0;
    end else begin
      core_ce_q <= 1'b0;
      case (state_q)
        S_REQ: begin
          req_a_q  <= core_a[ADDR_W-1:0];
          req_o_q  <= core_o;
          req_w_q  <= core_w;
          cnt_q    <= 2'd0;
          // Lane 0 is presented directly from the core inputs so B0 drives it.
          mem_a_q  <= core_a[ADDR_W-1:0];
          mem_d_q  <= byte_lane(core_o, 2'd0);
          mem_we_q <= core_w;
          state_q  <= S_BYTE;
        end
        S_BYTE: begin
          // mem_q now holds the byte addressed in the previous B cycle.
          if (!req_w_q && cnt_q != 2'd0) begin
            rbuf_q <= put_lane(rbuf_q, cnt_q - 2'd1, mem_q);
          end
          cnt_q <= cnt_d;
          if (cnt_q == 2'd3) begin
            mem_we_q <= 1'b0;
            state_q  <= S_TAIL;
          end else begin
            mem_a_q  <= lane_addr_d;
            mem_d_q  <= byte_lane(req_o_q, cnt_d);
            mem_we_q <= req_w_q;
          end
        end
        S_TAIL: begin
          mem_we_q <= 1'b0;
          if (!req_w_q) begin
            rbuf_q   <= put_lane(rbuf_q, 2'd3, mem_q);
            core_i_q <= put_lane(rbuf_q, 2'd3, mem_q);
          end
          core_ce_q <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          mem_we_q <= 1'b0;
          state_q  <= S_REQ;
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= S_REQ;
        end
      endcase
    end
  end

  assign core_i  = core_i_q;
  assign core_ce = core_ce_q;
  assign mem_a   = mem_a_q;
  assign mem_d   = mem_d_q;
  assign mem_we  = mem_we_q;

endmodule

// File: tb/tb_c32_mem.sv
// Directed bench for c32_mem: byte RAM model with 1-cycle read latency and
// a linear sequence of core transactions checked against hand-computed values.
module tb_c32_mem;

  localparam int ADDR_W = 20;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [31:0]       core_a;
  logic [31:0]       core_o;
  logic              core_w;
  logic [31:0]       core_i;
  logic              core_ce;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_d;
  logic              mem_we;
  logic [7:0]        mem_q;

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_a;
  logic [7:0]        pre_d;

  int checks = 0;
  int errors = 0;
  int ncyc;
  logic [ADDR_W-1:0] log_a  [0:5];
  logic              log_we [0:5];
  logic [7:0]        log_d  [0:5];

  always #5 clock = ~clock;

  c32_mem #(.ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .core_a  (core_a),
    .core_o  (core_o),
    .core_w  (core_w),
    .core_i  (core_i),
    .core_ce (core_ce),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_we  (mem_we),
    .mem_q   (mem_q)
  );

  always @(posedge clock) begin
    if (mem_we) ram[mem_a] <= mem_d;
    else if (pre_we) ram[pre_a] <= pre_d;
    mem_q <= ram[mem_a];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // Called at the negedge of the REQ cycle; returns at the DONE negedge.
  // ncyc counts cycles REQ=1 .. DONE=7; logs index B0..B3, TAIL, DONE.
  task automatic run_txn();
    ncyc = 1;
    for (int k = 0; k < 6; k++) begin
      log_a[k]  = '0;
      log_we[k] = 1'b0;
      log_d[k]  = '0;
    end
    while (ncyc < 12) begin
      @(negedge clock);
      ncyc++;
      if (ncyc - 2 < 6) begin
        log_a[ncyc-2]  = mem_a;
        log_we[ncyc-2] = mem_we;
        log_d[ncyc-2]  = mem_d;
      end
      if (core_ce) break;
    end
    $display("txn a=%h o=%h w=%b cycles=%0d core_i=%h", core_a, core_o, core_w, ncyc, core_i);
  endtask

  // From the DONE negedge: present the next request and step into its REQ cycle.
  task automatic start_next(input logic [31:0] a, input logic [31:0] o, input logic w);
    core_a = a;
    core_o = o;
    core_w = w;
    @(negedge clock);
    check("ce_single_cycle", {31'd0, core_ce}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    pre_we  = 1'b0;
    pre_a   = '0;
    pre_d   = '0;
    core_a  = 32'h0000_0100;
    core_o  = 32'h0;
    core_w  = 1'b0;
    repeat (3) @(negedge clock);

    preload(20'h00100, 8'h11);
    preload(20'h00101, 8'h22);
    preload(20'h00102, 8'h33);
    preload(20'h00103, 8'h44);
    preload(20'hFFFFF, 8'hAA);
    preload(20'h00000, 8'hBB);
    preload(20'h00001, 8'hCC);
    preload(20'h00002, 8'hDD);
    for (int k = 0; k < 4; k++) preload(20'h00300 + 20'(k), 8'h55);

    check("reset_ce", {31'd0, core_ce}, 32'd0);
    check("reset_we", {31'd0, mem_we}, 32'd0);
    check("reset_core_i", core_i, 32'h0);
    check("reset_mem_a", {12'd0, mem_a}, 32'h0);

    // Aligned read; the release cycle is the REQ cycle.
    reset_n = 1'b1;
    run_txn();
    check("first_ce_latency", ncyc, 32'd7);
    check("rd_mem_a_lo", {log_a[1][15:0], log_a[0][15:0]}, 32'h0101_0100);
    check("rd_mem_a_hi", {log_a[3][15:0], log_a[2][15:0]}, 32'h0103_0102);
    check("rd_no_we", {26'd0, log_we[5], log_we[4], log_we[3], log_we[2], log_we[1], log_we[0]}, 32'd0);
    check("rd_core_i", core_i, 32'h4433_2211);

    // Aligned write
    start_next(32'h0000_0200, 32'hDEAD_BEEF, 1'b1);
    run_txn();
    check("wr_latency", ncyc, 32'd7);
    check("wr_strobes", {26'd0, log_we[5], log_we[4], log_we[3], log_we[2], log_we[1], log_we[0]}, 32'h0000_000F);
    check("wr_bytes", {log_d[3], log_d[2], log_d[1], log_d[0]}, 32'hDEAD_BEEF);
    check("wr_mem_a_lo", {log_a[1][15:0], log_a[0][15:0]}, 32'h0201_0200);
    check("wr_mem_a_hi", {log_a[3][15:0], log_a[2][15:0]}, 32'h0203_0202);
    check("wr_ram", {ram[20'h203], ram[20'h202], ram[20'h201], ram[20'h200]}, 32'hDEAD_BEEF);
    check("wr_core_i_kept", core_i, 32'h4433_2211);

    // Unaligned read wrapping the address space; upper core address bits ignored
    start_next(32'h123F_FFFF, 32'h0, 1'b0);
    run_txn();
    check("wrap_mem_a0", {12'd0, log_a[0]}, 32'h000F_FFFF);
    check("wrap_mem_a1", {12'd0, log_a[1]}, 32'h0000_0000);
    check("wrap_mem_a3", {12'd0, log_a[3]}, 32'h0000_0002);
    check("wrap_core_i", core_i, 32'hDDCC_BBAA);

    // Back-to-back write then read of the same word
    start_next(32'h0000_0010, 32'h1234_5678, 1'b1);
    run_txn();
    check("b2b_wr_spacing", ncyc, 32'd7);
    start_next(32'h0000_0010, 32'h0, 1'b0);
    run_txn();
    check("b2b_rd_spacing", ncyc, 32'd7);
    check("b2b_rd_data", core_i, 32'h1234_5678);

    // Reset mid-write: pulled during B1 so the edge that would start B2 is the reset edge
    start_next(32'h0000_0300, 32'hA1B2_C3D4, 1'b1);
    @(negedge clock);
    @(negedge clock);
    check("midwr_strobing", {31'd0, mem_we}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check("midwr_we_drop", {31'd0, mem_we}, 32'd0);
    check("midwr_core_i_reset", core_i, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("midwr_we_held", {31'd0, mem_we}, 32'd0);
    end
    check("midwr_ram", {ram[20'h303], ram[20'h302], ram[20'h301], ram[20'h300]}, 32'h5555_C3D4);

    core_a  = 32'h0000_0300;
    core_o  = 32'h0;
    core_w  = 1'b0;
    reset_n = 1'b1;
    run_txn();
    check("post_reset_latency", ncyc, 32'd7);
    check("post_reset_read", core_i, 32'h5555_C3D4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
